tlb: RTL and testbench
======================

# tlb

Fully associative, TLBNUM-entry LoongArch-style TLB that answers the translation lookups issued by the instruction-side and data-side MMUs. It provides two combinational search ports (s0 for fetch, s1 for load/store), one synchronous write port for TLBWR/TLBFILL, one combinational read port for TLBRD, and INVTLB invalidation. It sits beside the CSR file in the CPU core: the MMUs drive the search ports, and the EX/WB stage drives write, read and invalidate.

## Interface
- TLBNUM, 16: entry count, a power of two from 4 to 32; IDXW = $clog2(TLBNUM).
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- s0_vppn / s1_vppn  in  19  search VA[31:13].
- s0_va_bit12 / s1_va_bit12  in  1  search VA[12].
- s0_asid / s1_asid  in  10  search ASID.
- s0_found / s1_found  out  1  hit.
- s0_index / s1_index  out  IDXW  hit entry index.
- s0_ppn / s1_ppn  out  20; s0_ps / s1_ps  out  6; s0_plv / s1_plv  out  2; s0_mat / s1_mat  out  2; s0_d / s1_d, s0_v / s1_v  out  1: fields of the selected half-page.
- invtlb_valid  in  1; invtlb_op  in  5: invalidate request and opcode. Operands come from s1_asid and s1_vppn.
- we  in  1; w_index  in  IDXW: write strobe and target entry.
- w_e, w_g  in  1; w_vppn  in  19; w_ps  in  6; w_asid  in  10: entry fields to write.
- w_ppn0/w_ppn1  in  20; w_plv0/1  in  2; w_mat0/1  in  2; w_d0/1, w_v0/1  in  1: even and odd page fields to write.
- r_index  in  IDXW; r_e, r_g, r_vppn, r_ps, r_asid, r_ppn0/1, r_plv0/1, r_mat0/1, r_d0/1, r_v0/1  out: read port, same widths as the w_ fields.

## Operation
- State: one register set per entry holding e, g, vppn, ps, asid, ppn0/1, plv0/1, mat0/1, d0/1, v0/1.
- Match for port x and entry i: e[i] & (g[i] | asid[i]==sx_asid) & (ps[i]==12 ? vppn[i]==sx_vppn : vppn[i][18:9]==sx_vppn[18:9]).
- Half-page select: odd = (ps==12) ? sx_va_bit12 : sx_vppn[8]. odd=1 returns the *1 fields, odd=0 returns the *0 fields.
- Multiple hits: the lowest matching index wins. Software never creates multiple hits, but the output must still be deterministic.
- No hit: found=0 and every other search output is 0.
- Only w_ps values 12 and 21 are legal. Other values are stored as written and compared as 2 MB pages (the ps!=12 branch).
- Write: when we=1 at a clock edge, every field of entry w_index is loaded.
- INVTLB: when invtlb_valid=1 at a clock edge, e is cleared on every entry that satisfies the condition for its op:
  - op 0 or 1: all entries.
  - op 2: g=1.
  - op 3: g=0.
  - op 4: g=0 & asid==s1_asid.
  - op 5: g=0 & asid==s1_asid & VA match.
  - op 6: (g=1 | asid==s1_asid) & VA match.
  - op ≥7: no change. The core raises INE for these opcodes.
- VA match for INVTLB uses the same ps-dependent vppn comparison as search.
- Read: r_* shows entry r_index combinationally.

## Timing
- Search and read are combinational and reflect register state at the start of the cycle. A write or invalidate in cycle N becomes visible to search and read in cycle N+1.
- Reset: all e cleared in one cycle. All other entry fields reset to 0. Outputs after reset: found=0, all search outputs 0, r_* = 0.
- we and invtlb_valid in the same cycle: the invalidate is evaluated on the pre-edge state and the write is then applied. Entry w_index ends up with exactly the written fields (write wins). Other entries follow the invalidate.
- reset together with we or invtlb_valid: reset wins, and all entries end invalid.
- There is no handshake and no stall; every request completes at its edge.

## Test plan
- Reset, then search s0 with any VA and s1 with any VA -> found=0 and all search outputs 0 on both ports.
- Write index 3 with e=1, g=0, asid=0x5, vppn=0x00400, ps=12, ppn0=0x11111, ppn1=0x22222, v0=v1=1. Next cycle:
  - s0 search with vppn=0x00400, bit12=1, asid=0x5 -> found=1, index=3, ppn=0x22222.
  - Same search with asid=0x6 -> found=0.
- Write index 7 with e=1, g=1, ps=21, vppn=0x12300, ppn0=0xAAAAA, ppn1=0xBBBBB. Search with vppn=0x123FF, asid=0x3FF -> found=1, index=7, ppn=0xBBBBB (sx_vppn[8]=1).
- Load entries 0 to 3 with matching and non-matching asid and g combinations. Issue invtlb op 5 with s1_asid=0x5 and s1_vppn=0x00400 -> only the g=0, asid-5, VA-matching entry has r_e=0 next cycle.
- Same cycle: invtlb op 0 and a write to index 2 with e=1 -> next cycle only entry 2 is valid.
- Identical valid entries at indices 4 and 9 -> search returns index=4 with entry 4's fields.

Source files
------------

// File: rtl/tlb_if.sv
// tlb_if: core-side bundle for the TLB (two search ports, write, read, invtlb).
//   slave  : TLB side (search/read results are outputs)
//   master : core side (MMUs and EX/WB drive requests)
interface tlb_if #(
  parameter int unsigned TLBNUM = 16
);
  localparam int unsigned IDXW = $clog2(TLBNUM);

  // search port 0 (fetch)
  logic [18:0]     s0_vppn;
  logic            s0_va_bit12;
  logic [9:0]      s0_asid;
  logic            s0_found;
  logic [IDXW-1:0] s0_index;
  logic [19:0]     s0_ppn;
  logic [5:0]      s0_ps;
  logic [1:0]      s0_plv;
  logic [1:0]      s0_mat;
  logic            s0_d;
  logic            s0_v;

  // search port 1 (load/store), also supplies invtlb operands
  logic [18:0]     s1_vppn;
  logic            s1_va_bit12;
  logic [9:0]      s1_asid;
  logic            s1_found;
  logic [IDXW-1:0] s1_index;
  logic [19:0]     s1_ppn;
  logic [5:0]      s1_ps;
  logic [1:0]      s1_plv;
  logic [1:0]      s1_mat;
  logic            s1_d;
  logic            s1_v;

  // invalidate
  logic            invtlb_valid;
  logic [4:0]      invtlb_op;

  // write port
  logic            we;
  logic [IDXW-1:0] w_index;
  logic            w_e;
  logic            w_g;
  logic [18:0]     w_vppn;
  logic [5:0]      w_ps;
  logic [9:0]      w_asid;
  logic [19:0]     w_ppn0;
  logic [19:0]     w_ppn1;
  logic [1:0]      w_plv0;
  logic [1:0]      w_plv1;
  logic [1:0]      w_mat0;
  logic [1:0]      w_mat1;
  logic            w_d0;
  logic            w_d1;
  logic            w_v0;
  logic            w_v1;

  // read port
  logic [IDXW-1:0] r_index;
  logic            r_e;
  logic            r_g;
  logic [18:0]     r_vppn;
  logic [5:0]      r_ps;
  logic [9:0]      r_asid;
  logic [19:0]     r_ppn0;
  logic [19:0]     r_ppn1;
  logic [1:0]      r_plv0;
  logic [1:0]      r_plv1;
  logic [1:0]      r_mat0;
  logic [1:0]      r_mat1;
  logic            r_d0;
  logic            r_d1;
  logic            r_v0;
  logic            r_v1;

  modport slave (
    input  s0_vppn, s0_va_bit12, s0_asid,
    output s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
    input  s1_vppn, s1_va_bit12, s1_asid,
    output s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
    input  invtlb_valid, invtlb_op,
    input  we, w_index, w_e, w_g, w_vppn, w_ps, w_asid,
    input  w_ppn0, w_ppn1, w_plv0, w_plv1, w_mat0, w_mat1, w_d0, w_d1, w_v0, w_v1,
    input  r_index,
    output r_e, r_g, r_vppn, r_ps, r_asid,
    output r_ppn0, r_ppn1, r_plv0, r_plv1, r_mat0, r_mat1, r_d0, r_d1, r_v0, r_v1
  );

  modport master (
    output s0_vppn, s0_va_bit12, s0_asid,
    input  s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
    output s1_vppn, s1_va_bit12, s1_asid,
    input  s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
    output invtlb_valid, invtlb_op,
    output we, w_index, w_e, w_g, w_vppn, w_ps, w_asid,
    output w_ppn0, w_ppn1, w_plv0, w_plv1, w_mat0, w_mat1, w_d0, w_d1, w_v0, w_v1,
    output r_index,
    input  r_e, r_g, r_vppn, r_ps, r_asid,
    input  r_ppn0, r_ppn1, r_plv0, r_plv1, r_mat0, r_mat1, r_d0, r_d1, r_v0, r_v1
  );
endinterface

// File: rtl/tlb.sv
// tlb: fully associative LoongArch-style TLB.
//   clk, reset : core clock, synchronous active-high reset
//   bus        : tlb_if.slave -- combinational search ports s0/s1, combinational
//                read port r_*, synchronous write port w_*, INVTLB (operands on s1)
// Search/read see state at the start of the cycle; write/invalidate land at the edge.
module tlb #(
  parameter int unsigned TLBNUM = 16
) (
  input  logic  clk,
  input  logic  reset,
  tlb_if.slave  bus
);
  localparam int unsigned IDXW = $clog2(TLBNUM);

  typedef struct packed {
    logic        e;
    logic        g;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic [19:0] ppn0;
    logic [19:0] ppn1;
    logic [1:0]  plv0;
    logic [1:0]  plv1;
    logic [1:0]  mat0;
    logic [1:0]  mat1;
    logic        d0;
    logic        d1;
    logic        v0;
    logic        v1;
  } entry_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] index;
    logic [19:0]     ppn;
    logic [5:0]      ps;
    logic [1:0]      plv;
    logic [1:0]      mat;
    logic            d;
    logic            v;
  } hit_t;

  entry_t entry_q [TLBNUM];
  entry_t entry_d [TLBNUM];
  entry_t w_entry;
  entry_t r_entry;
  hit_t   s0_hit;
  hit_t   s1_hit;

  // 4 KB pages compare the full vppn; anything else is treated as a 2 MB page
  function automatic logic va_match(entry_t ent, logic [18:0] vppn);
    if (ent.ps == 6'd12) return ent.vppn == vppn;
    return ent.vppn[18:9] == vppn[18:9];
  endfunction

  // Scan high to low so the lowest matching index is the one left in the result
  function automatic hit_t lookup(logic [18:0] vppn, logic bit12, logic [9:0] asid);
    hit_t res;
    logic odd;
    res = '0;
    odd = 1'b0;
    for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
      if (entry_q[i].e && (entry_q[i].g || entry_q[i].asid == asid) &&
          va_match(entry_q[i], vppn)) begin
        odd       = (entry_q[i].ps == 6'd12) ? bit12 : vppn[8];
        res.found = 1'b1;
        res.index = IDXW'(i);
        res.ps    = entry_q[i].ps;
        res.ppn   = odd ? entry_q[i].ppn1 : entry_q[i].ppn0;
        res.plv   = odd ? entry_q[i].plv1 : entry_q[i].plv0;
        res.mat   = odd ? entry_q[i].mat1 : entry_q[i].mat0;
        res.d     = odd ? entry_q[i].d1   : entry_q[i].d0;
        res.v     = odd ? entry_q[i].v1   : entry_q[i].v0;
      end
    end
    return res;
  endfunction

  // INVTLB selection; opcodes 7 and above select nothing
  function automatic logic inv_sel(entry_t ent, logic [4:0] op,
                                   logic [9:0] asid, logic [18:0] vppn);
    logic asid_eq;
    asid_eq = (ent.asid == asid);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return ent.g;
      5'd3:       return !ent.g;
      5'd4:       return !ent.g && asid_eq;
      5'd5:       return !ent.g && asid_eq && va_match(ent, vppn);
      5'd6:       return (ent.g || asid_eq) && va_match(ent, vppn);
      default:    return 1'b0;
    endcase
  endfunction

  // Write payload assembled from the w_* fields
  always_comb begin
    w_entry      = '0;
    w_entry.e    = bus.w_e;
    w_entry.g    = bus.w_g;
    w_entry.vppn = bus.w_vppn;
    w_entry.ps   = bus.w_ps;
    w_entry.asid = bus.w_asid;
    w_entry.ppn0 = bus.w_ppn0;
    w_entry.ppn1 = bus.w_ppn1;
    w_entry.plv0 = bus.w_plv0;
    w_entry.plv1 = bus.w_plv1;
    w_entry.mat0 = bus.w_mat0;
    w_entry.mat1 = bus.w_mat1;
    w_entry.d0   = bus.w_d0;
    w_entry.d1   = bus.w_d1;
    w_entry.v0   = bus.w_v0;
    w_entry.v1   = bus.w_v1;
  end

  // Next state: invalidate on pre-edge state, then the write overrides its entry
  always_comb begin
    for (int i = 0; i < int'(TLBNUM); i++) begin
      entry_d[i] = entry_q[i];
      if (bus.invtlb_valid &&
          inv_sel(entry_q[i], bus.invtlb_op, bus.s1_asid, bus.s1_vppn)) begin
        entry_d[i].e = 1'b0;
      end
      if (bus.we && bus.w_index == IDXW'(i)) begin
        entry_d[i] = w_entry;
      end
    end
  end

  // Entry storage; reset overrides any same-cycle write or invalidate
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(TLBNUM); i++) begin
      if (reset) entry_q[i] <= '0;
      else       entry_q[i] <= entry_d[i];
    end
  end

  // Search ports
  always_comb begin
    s0_hit = lookup(bus.s0_vppn, bus.s0_va_bit12, bus.s0_asid);
    s1_hit = lookup(bus.s1_vppn, bus.s1_va_bit12, bus.s1_asid);
  end

  assign bus.s0_found = s0_hit.found;
  assign bus.s0_index = s0_hit.index;
  assign bus.s0_ppn   = s0_hit.ppn;
  assign bus.s0_ps    = s0_hit.ps;
  assign bus.s0_plv   = s0_hit.plv;
  assign bus.s0_mat   = s0_hit.mat;
  assign bus.s0_d     = s0_hit.d;
  assign bus.s0_v     = s0_hit.v;

  assign bus.s1_found = s1_hit.found;
  assign bus.s1_index = s1_hit.index;
  assign bus.s1_ppn   = s1_hit.ppn;
  assign bus.s1_ps    = s1_hit.ps;
  assign bus.s1_plv   = s1_hit.plv;
  assign bus.s1_mat   = s1_hit.mat;
  assign bus.s1_d     = s1_hit.d;
  assign bus.s1_v     = s1_hit.v;

  // Read port
  assign r_entry    = entry_q[bus.r_index];
  assign bus.r_e    = r_entry.e;
  assign bus.r_g    = r_entry.g;
  assign bus.r_vppn = r_entry.vppn;
  assign bus.r_ps   = r_entry.ps;
  assign bus.r_asid = r_entry.asid;
  assign bus.r_ppn0 = r_entry.ppn0;
  assign bus.r_ppn1 = r_entry.ppn1;
  assign bus.r_plv0 = r_entry.plv0;
  assign bus.r_plv1 = r_entry.plv1;
  assign bus.r_mat0 = r_entry.mat0;
  assign bus.r_mat1 = r_entry.mat1;
  assign bus.r_d0   = r_entry.d0;
  assign bus.r_d1   = r_entry.d1;
  assign bus.r_v0   = r_entry.v0;
  assign bus.r_v1   = r_entry.v1;
endmodule

// File: tb/tb_tlb.sv
// tb_tlb: directed, table-driven bench for tlb (TLBNUM=16).
module tb_tlb;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  tlb_if #(.TLBNUM(16)) bus ();
  tlb #(.TLBNUM(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [18:0] vppn;
    logic        b12;
    logic [9:0]  asid;
    logic        found;
    logic [3:0]  idx;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } svec_t;

  svec_t vec [10];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] idx, input logic e, input logic g,
                             input logic [18:0] vppn, input logic [5:0] ps,
                             input logic [9:0] asid, input logic [19:0] ppn0,
                             input logic [19:0] ppn1, input logic [1:0] plv0,
                             input logic [1:0] plv1, input logic [1:0] mat0,
                             input logic [1:0] mat1, input logic d0, input logic d1,
                             input logic v0, input logic v1);
    bus.we = 1'b1; bus.w_index = idx; bus.w_e = e; bus.w_g = g;
    bus.w_vppn = vppn; bus.w_ps = ps; bus.w_asid = asid;
    bus.w_ppn0 = ppn0; bus.w_ppn1 = ppn1; bus.w_plv0 = plv0; bus.w_plv1 = plv1;
    bus.w_mat0 = mat0; bus.w_mat1 = mat1; bus.w_d0 = d0; bus.w_d1 = d1;
    bus.w_v0 = v0; bus.w_v1 = v1;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic set_s0(input logic [18:0] vppn, input logic b12, input logic [9:0] asid);
    bus.s0_vppn = vppn; bus.s0_va_bit12 = b12; bus.s0_asid = asid;
  endtask

  task automatic set_s1(input logic [18:0] vppn, input logic b12, input logic [9:0] asid);
    bus.s1_vppn = vppn; bus.s1_va_bit12 = b12; bus.s1_asid = asid;
  endtask

  // All search outputs of both ports must be zero
  task automatic chk_no_hit(string tag);
    chk($sformatf("%s_s0_all", tag),
        {bus.s0_found, 4'(bus.s0_index), bus.s0_ppn, bus.s0_d, bus.s0_v}, 32'h0);
    chk($sformatf("%s_s0_attr", tag), {bus.s0_ps, bus.s0_plv, bus.s0_mat}, 32'h0);
    chk($sformatf("%s_s1_all", tag),
        {bus.s1_found, 4'(bus.s1_index), bus.s1_ppn, bus.s1_d, bus.s1_v}, 32'h0);
    chk($sformatf("%s_s1_attr", tag), {bus.s1_ps, bus.s1_plv, bus.s1_mat}, 32'h0);
  endtask

  task automatic chk_valid_map(string tag, logic [15:0] exp);
    logic [15:0] got;
    got = '0;
    for (int i = 0; i < 16; i++) begin
      bus.r_index = 4'(i);
      #1;
      got[i] = bus.r_e;
    end
    chk(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    logic        f;
    logic [3:0]  ix;
    logic [19:0] pp;
    logic [5:0]  ps;
    logic [1:0]  pl;
    logic [1:0]  mt;
    logic        dd;
    logic        vv;

    checks = 0;
    errors = 0;

    //           port vppn     b12  asid    found idx ppn       ps     plv  mat  d  v
    vec[0] = '{1'b0, 19'h00400, 1'b1, 10'h005, 1'b1, 4'd3, 20'h22222, 6'd12, 2'd3, 2'd1, 1'b1, 1'b1};
    vec[1] = '{1'b0, 19'h00400, 1'b0, 10'h005, 1'b1, 4'd3, 20'h11111, 6'd12, 2'd0, 2'd0, 1'b0, 1'b1};
    vec[2] = '{1'b0, 19'h00400, 1'b1, 10'h006, 1'b0, 4'd0, 20'h00000, 6'd0,  2'd0, 2'd0, 1'b0, 1'b0};
    vec[3] = '{1'b1, 19'h123FF, 1'b0, 10'h3FF, 1'b1, 4'd7, 20'hBBBBB, 6'd21, 2'd2, 2'd1, 1'b0, 1'b1};
    vec[4] = '{1'b1, 19'h12200, 1'b1, 10'h001, 1'b1, 4'd7, 20'hAAAAA, 6'd21, 2'd1, 2'd1, 1'b1, 1'b1};
    vec[5] = '{1'b1, 19'h12400, 1'b0, 10'h000, 1'b0, 4'd0, 20'h00000, 6'd0,  2'd0, 2'd0, 1'b0, 1'b0};
    vec[6] = '{1'b0, 19'h00401, 1'b0, 10'h005, 1'b0, 4'd0, 20'h00000, 6'd0,  2'd0, 2'd0, 1'b0, 1'b0};
    vec[7] = '{1'b0, 19'h05000, 1'b1, 10'h007, 1'b1, 4'd4, 20'h45454, 6'd12, 2'd1, 2'd2, 1'b0, 1'b1};
    vec[8] = '{1'b1, 19'h05000, 1'b0, 10'h007, 1'b1, 4'd4, 20'h44444, 6'd12, 2'd0, 2'd2, 1'b1, 1'b1};
    vec[9] = '{1'b1, 19'h05000, 1'b0, 10'h008, 1'b0, 4'd0, 20'h00000, 6'd0,  2'd0, 2'd0, 1'b0, 1'b0};

    reset = 1'b1;
    bus.we = 1'b0; bus.w_index = '0; bus.w_e = 1'b0; bus.w_g = 1'b0;
    bus.w_vppn = '0; bus.w_ps = '0; bus.w_asid = '0; bus.w_ppn0 = '0; bus.w_ppn1 = '0;
    bus.w_plv0 = '0; bus.w_plv1 = '0; bus.w_mat0 = '0; bus.w_mat1 = '0;
    bus.w_d0 = 1'b0; bus.w_d1 = 1'b0; bus.w_v0 = 1'b0; bus.w_v1 = 1'b0;
    bus.invtlb_valid = 1'b0; bus.invtlb_op = '0; bus.r_index = '0;
    set_s0(19'h00400, 1'b1, 10'h005);
    set_s1(19'h7FFFF, 1'b0, 10'h000);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    chk_no_hit("reset");
    chk("reset_r_fields", {bus.r_e, bus.r_g, bus.r_vppn, bus.r_asid[1:0]}, 32'h0);
    chk("reset_r_ppn", {bus.r_ppn0[15:0], bus.r_ppn1[15:0]}, 32'h0);
    chk_valid_map("reset_valid_map", 16'h0000);

    // Populate: 4 KB entry, 2 MB global entry, two entries with identical tags
    write_entry(4'd3, 1, 0, 19'h00400, 6'd12, 10'h005, 20'h11111, 20'h22222,
                2'd0, 2'd3, 2'd0, 2'd1, 0, 1, 1, 1);
    write_entry(4'd7, 1, 1, 19'h12300, 6'd21, 10'h000, 20'hAAAAA, 20'hBBBBB,
                2'd1, 2'd2, 2'd1, 2'd1, 1, 0, 1, 1);
    write_entry(4'd4, 1, 0, 19'h05000, 6'd12, 10'h007, 20'h44444, 20'h45454,
                2'd0, 2'd1, 2'd2, 2'd2, 1, 0, 1, 1);
    write_entry(4'd9, 1, 0, 19'h05000, 6'd12, 10'h007, 20'h99990, 20'h99991,
                2'd3, 2'd3, 2'd0, 2'd0, 0, 0, 1, 1);

    for (int k = 0; k < 10; k++) begin
      if (vec[k].port) begin
        set_s0(19'h7FFFF, 1'b0, 10'h000);
        set_s1(vec[k].vppn, vec[k].b12, vec[k].asid);
        #1;
        f = bus.s1_found; ix = bus.s1_index; pp = bus.s1_ppn; ps = bus.s1_ps;
        pl = bus.s1_plv; mt = bus.s1_mat; dd = bus.s1_d; vv = bus.s1_v;
      end else begin
        set_s1(19'h7FFFF, 1'b0, 10'h000);
        set_s0(vec[k].vppn, vec[k].b12, vec[k].asid);
        #1;
        f = bus.s0_found; ix = bus.s0_index; pp = bus.s0_ppn; ps = bus.s0_ps;
        pl = bus.s0_plv; mt = bus.s0_mat; dd = bus.s0_d; vv = bus.s0_v;
      end
      chk($sformatf("vec%0d_found", k), 32'(f), 32'(vec[k].found));
      chk($sformatf("vec%0d_index", k), 32'(ix), 32'(vec[k].idx));
      chk($sformatf("vec%0d_ppn", k), 32'(pp), 32'(vec[k].ppn));
      chk($sformatf("vec%0d_attr", k), {20'h0, ps, pl, mt, dd, vv},
          {20'h0, vec[k].ps, vec[k].plv, vec[k].mat, vec[k].d, vec[k].v});
    end

    // Read port shows a stored entry verbatim
    bus.r_index = 4'd7;
    #1;
    chk("read7_tag", {bus.r_e, bus.r_g, bus.r_ps, bus.r_vppn}, {1'b1, 1'b1, 6'd21, 19'h12300});
    chk("read7_ppn1", 32'(bus.r_ppn1), 32'hBBBBB);

    // Reset together with a write: reset wins
    reset = 1'b1;
    write_entry(4'd5, 1, 1, 19'h00400, 6'd12, 10'h005, 20'h55555, 20'h55555,
                2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 1);
    reset = 1'b0;
    chk_valid_map("reset_vs_write_map", 16'h0000);
    bus.r_index = 4'd5;
    #1;
    chk("reset_vs_write_r5", {bus.r_vppn, bus.r_g}, 32'h0);
    set_s0(19'h00400, 1'b1, 10'h005);
    set_s1(19'h05000, 1'b0, 10'h007);
    #1;
    chk_no_hit("after_reset2");

    // INVTLB op 5: only the non-global, asid 5, VA-matching entry goes away
    write_entry(4'd0, 1, 0, 19'h00400, 6'd12, 10'h005, 20'h10000, 20'h20000,
                2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 1);
    write_entry(4'd1, 1, 1, 19'h00400, 6'd12, 10'h005, 20'h10001, 20'h20001,
                2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 1);
    write_entry(4'd2, 1, 0, 19'h00400, 6'd12, 10'h006, 20'h10002, 20'h20002,
                2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 1);
    write_entry(4'd3, 1, 0, 19'h00800, 6'd12, 10'h005, 20'h10003, 20'h20003,
                2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 1);
    set_s0(19'h00400, 1'b0, 10'h005);
    #1;
    chk("pre_inv_s0_index", {31'h0, bus.s0_found} << 8 | 32'(bus.s0_index), 32'h100);
    set_s1(19'h00400, 1'b0, 10'h005);
    bus.invtlb_op = 5'd5;
    bus.invtlb_valid = 1'b1;
    tick();
    bus.invtlb_valid = 1'b0;
    chk_valid_map("inv5_map", 16'h000E);
    #1;
    chk("inv5_s0_found", 32'(bus.s0_found), 32'h1);
    chk("inv5_s0_index", 32'(bus.s0_index), 32'h1);
    chk("inv5_s0_ppn", 32'(bus.s0_ppn), 32'h10001);

    // Opcode 7 is a no-op
    bus.invtlb_op = 5'd7;
    bus.invtlb_valid = 1'b1;
    tick();
    bus.invtlb_valid = 1'b0;
    chk_valid_map("inv7_map", 16'h000E);

    // Opcode 2 removes only global entries
    bus.invtlb_op = 5'd2;
    bus.invtlb_valid = 1'b1;
    tick();
    bus.invtlb_valid = 1'b0;
    chk_valid_map("inv2_map", 16'h000C);

    // Opcode 0 plus same-cycle write to index 2: write wins on its entry
    bus.invtlb_op = 5'd0;
    bus.invtlb_valid = 1'b1;
    write_entry(4'd2, 1, 0, 19'h00600, 6'd12, 10'h009, 20'h12345, 20'h54321,
                2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 1);
    bus.invtlb_valid = 1'b0;
    chk_valid_map("inv0_write_map", 16'h0004);
    bus.r_index = 4'd2;
    #1;
    chk("inv0_write_r2", {bus.r_ppn0, 2'b0, bus.r_asid}, {20'h12345, 2'b0, 10'h009});
    set_s1(19'h00600, 1'b1, 10'h009);
    #1;
    chk("inv0_write_s1", {11'h0, bus.s1_found, bus.s1_ppn}, {11'h0, 1'b1, 20'h54321});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
